// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (99..00) with a prescaler tick, load/start/pause
// controls and registered running/done status for a seven-segment display stage.
module bcd_countdown_timer #(
   parameter int TICK_DIV = 50000000,
   parameter int TICK_W   = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       running,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   state_t            state_reg, state_next;
   logic [3:0]        tens_reg, tens_next;
   logic [3:0]        ones_reg, ones_next;
   logic [TICK_W-1:0] presc_reg, presc_next;
   logic              running_reg;
   logic              done_reg;

   // Digits above 9 would confuse the downstream display decoder.
   function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   always_comb begin
      state_next = state_reg;
      tens_next  = tens_reg;
      ones_next  = ones_reg;
      presc_next = presc_reg;
      if (load) begin
         tens_next  = clamp_bcd(load_tens);
         ones_next  = clamp_bcd(load_ones);
         presc_next = '0;
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start && (tens_reg != 4'd0 || ones_reg != 4'd0)) begin
                  state_next = RUN;
                  presc_next = '0;
               end
            end
            RUN: begin
               // Pause beats a coincident tick: prescaler and count both hold.
               if (pause) begin
                  state_next = PAUSED;
               end else if (presc_reg == TICK_LAST) begin
                  presc_next = '0;
                  if (ones_reg != 4'd0) begin
                     ones_next = ones_reg - 4'd1;
                  end else begin
                     ones_next = 4'd9;
                     tens_next = tens_reg - 4'd1;
                  end
                  if (tens_reg == 4'd0 && ones_reg == 4'd1)
                     state_next = DONE;
               end else begin
                  presc_next = presc_reg + TICK_W'(1);
               end
            end
            PAUSED: begin
               if (start && !pause)
                  state_next = RUN;
            end
            DONE: begin
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         tens_reg    <= 4'd0;
         ones_reg    <= 4'd0;
         presc_reg   <= '0;
         running_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         tens_reg    <= tens_next;
         ones_reg    <= ones_next;
         presc_reg   <= presc_next;
         running_reg <= (state_next == RUN);
         done_reg    <= (state_next == DONE);
      end
   end

   assign tens    = tens_reg;
   assign ones    = ones_reg;
   assign running = running_reg;
   assign done    = done_reg;

endmodule
